p2s_stream_arbiter: RTL and testbench

- Frame-level round-robin arbiter sharing one Par2Ser serializer among NUM_SRC parallel AXI-stream sources in the OFDM path.
- A grant is held from the first beat to the tlast beat of a frame, so serialized frames never interleave.
- The master side drives the serializer's s_axis input (din/din_vld/dout_rdy) directly.

---
 rtl/p2s_stream_arbiter_pkg.sv | 17 +
 rtl/p2s_stream_arbiter_rr_pick.sv | 42 ++++
 rtl/p2s_stream_arbiter.sv | 137 +++++++++++++
 tb/tb_p2s_stream_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_stream_arbiter_pkg.sv
// Shared definitions for the Par2Ser stream arbiter: FSM state encodings and
// the legal range of source counts.
package p2s_stream_arbiter_pkg;

    localparam int NUM_SRC_MIN = 2;
    localparam int NUM_SRC_MAX = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    function automatic logic num_src_ok(input int n);
        return (n >= NUM_SRC_MIN) && (n <= NUM_SRC_MAX);
    endfunction

endpackage

// File: rtl/p2s_stream_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder. The search starts at
// ptr+1 and wraps, so the requester at ptr has the lowest priority.
// Written generically so other shared-resource arbiters can reuse it.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_any;
    logic             lo_any;

    // Split requesters into those above ptr (searched first) and the rest;
    // descending scan with overwrite leaves the lowest index of each tier.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (req[j]) begin
                if (j > int'(ptr)) begin
                    hi_idx = IDX_W'(j);
                    hi_any = 1'b1;
                end else begin
                    lo_idx = IDX_W'(j);
                    lo_any = 1'b1;
                end
            end
        end
    end

    assign gnt_any = hi_any | lo_any;
    assign gnt_idx = hi_any ? hi_idx : lo_idx;

endmodule

// File: rtl/p2s_stream_arbiter.sv
// p2s_stream_arbiter: frame-level round-robin arbiter that shares one Par2Ser
// serializer among NUM_SRC AXI-stream sources. A grant is held from the first
// beat to the tlast beat, so frames never interleave on the serializer input.
//
// Optional build macro P2S_ARB_PRIO0_EN: source 0 (pilot/control frames) wins
// every arbitration it requests; round-robin applies among the other sources
// and the pointer only moves on non-zero grants.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; arbitrate among s_vld, register winner
// ST_LOCK | grant_id owns the serializer until its tlast beat transfers
module p2s_stream_arbiter
    import p2s_stream_arbiter_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int WIDTH   = 8,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*WIDTH-1:0] s_data,
    input  logic [NUM_SRC-1:0]       s_vld,
    input  logic [NUM_SRC-1:0]       s_last,
    output logic [NUM_SRC-1:0]       s_rdy,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_vld,
    output logic                     m_last,
    input  logic                     m_rdy,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     busy
);

    if (!num_src_ok(NUM_SRC)) begin : g_bad_num_src
        $error("p2s_stream_arbiter: NUM_SRC out of range");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;

    logic [NUM_SRC-1:0] rr_req;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_any;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic [WIDTH-1:0]   src_data [NUM_SRC];

    // Unpack the flat source data bus into one word per source.
    always_comb begin
        for (int j = 0; j < NUM_SRC; j++) begin
            src_data[j] = s_data[j*WIDTH +: WIDTH];
        end
    end

`ifdef P2S_ARB_PRIO0_EN
    assign rr_req = {s_vld[NUM_SRC-1:1], 1'b0};

    // Source 0 pre-empts the round-robin search whenever it is requesting.
    always_comb begin
        if (s_vld[0]) begin
            win_idx = '0;
            win_any = 1'b1;
        end else begin
            win_idx = rr_idx;
            win_any = rr_any;
        end
    end
`else
    assign rr_req  = s_vld;
    assign win_idx = rr_idx;
    assign win_any = rr_any;
`endif

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (rr_req),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // State, fairness pointer and owner registers; reset favours source 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_W'(NUM_SRC - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // Next-state logic plus the combinational pass-through of the owner.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        m_data  = '0;
        m_vld   = 1'b0;
        m_last  = 1'b0;
        s_rdy   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    grant_d = win_idx;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                m_data         = src_data[grant_q];
                m_vld          = s_vld[grant_q];
                m_last         = s_last[grant_q];
                s_rdy[grant_q] = m_rdy;
                if (s_vld[grant_q] && m_rdy && s_last[grant_q]) begin
                    state_d = ST_IDLE;
`ifdef P2S_ARB_PRIO0_EN
                    if (grant_q != '0) begin
                        ptr_d = grant_q;
                    end
`else
                    ptr_d = grant_q;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == ST_LOCK);

endmodule

// File: tb/tb_p2s_stream_arbiter.sv
// Directed testbench for p2s_stream_arbiter. Each source is fed from its own
// beat queue; the expected serializer stream is pushed to a scoreboard when
// the stimulus is loaded and checked beat by beat at the falling edge.
module tb_p2s_stream_arbiter;

    localparam int NS = 4;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NS*W-1:0] s_data;
    logic [NS-1:0] s_vld;
    logic [NS-1:0] s_last;
    logic [NS-1:0] s_rdy;
    logic [W-1:0]  m_data;
    logic          m_vld;
    logic          m_last;
    logic          m_rdy;
    logic [1:0]    grant_id;
    logic          busy;

    always #5 clk = ~clk;

    p2s_stream_arbiter #(.NUM_SRC(NS), .WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_vld    (s_vld),
        .s_last   (s_last),
        .s_rdy    (s_rdy),
        .m_data   (m_data),
        .m_vld    (m_vld),
        .m_last   (m_last),
        .m_rdy    (m_rdy),
        .grant_id (grant_id),
        .busy     (busy)
    );

    typedef struct packed {
        logic [2:0] src;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] src_q[NS][$];
    logic [NS-1:0] gap;
    logic       prev_last_xfer;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         used;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_chk++;
        n_fail++;
        $error("FAIL %s", tag);
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                s_data[i*W +: W] = src_q[i][0][7:0];
                s_last[i]        = src_q[i][0][8] & ~gap[i];
                s_vld[i]         = ~gap[i];
            end else begin
                s_vld[i]  = 1'b0;
                s_last[i] = 1'b0;
            end
        end
    endtask

    task automatic src_push(input int src, input logic [7:0] d, input logic l);
        src_q[src].push_back({l, d});
    endtask

    task automatic exp_push(input int src, input logic [7:0] d, input logic l);
        exp_t e;
        e.src  = 3'(src);
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    // One clock: check outputs at the falling edge, then advance sources.
    task automatic tick();
        exp_t e;
        logic [NS-1:0] hs;
        @(negedge clk);
        if (prev_last_xfer) chk("bubble_busy", 32'(busy), 32'd0);
        prev_last_xfer = 1'b0;
        if (m_vld === 1'b1) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_beat");
            end else begin
                e = sb[0];
                chk("beat_grant", 32'(grant_id), 32'(e.src));
                chk("beat_data", 32'(m_data), 32'(e.data));
                chk("beat_last", 32'(m_last), 32'(e.last));
                chk("beat_s_rdy", 32'(s_rdy), 32'(4'(m_rdy) << e.src));
                if (m_rdy) begin
                    void'(sb.pop_front());
                    prev_last_xfer = e.last;
                end
            end
        end
        hs = s_vld & s_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) void'(src_q[i].pop_front());
        end
        drive_srcs();
    endtask

    function automatic bit all_empty();
        bit e = (sb.size() == 0);
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic run_until_done(input int max, output int n);
        n = 0;
        while (!all_empty()) begin
            if (n >= max) begin
                fail_now("timeout_waiting_for_frames");
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic clear_all();
        sb.delete();
        for (int i = 0; i < NS; i++) src_q[i].delete();
        gap = '0;
        prev_last_xfer = 1'b0;
        s_vld  = '0;
        s_last = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        m_rdy = 1'b1;
        drive_srcs();
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_m_vld", 32'(m_vld), 32'd0);
        chk("rst_s_rdy", 32'(s_rdy), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        s_data = '0;
        s_vld  = '0;
        s_last = '0;
        m_rdy  = 1'b1;
        gap    = '0;
        prev_last_xfer = 1'b0;

        // Single source, three-beat frame on source 2.
        do_reset();
        src_push(2, 8'hA1, 1'b0); exp_push(2, 8'hA1, 1'b0);
        src_push(2, 8'hA2, 1'b0); exp_push(2, 8'hA2, 1'b0);
        src_push(2, 8'hA3, 1'b1); exp_push(2, 8'hA3, 1'b1);
        drive_srcs();
        #1;
        chk("t1_busy_same_cycle", 32'(busy), 32'd0);
        chk("t1_idle_s_rdy", 32'(s_rdy), 32'd0);
        tick();
        chk("t1_busy_next_cycle", 32'(busy), 32'd1);
        chk("t1_grant", 32'(grant_id), 32'd2);
        run_until_done(20, used);
        tick();
        chk("t1_back_idle", 32'(busy), 32'd0);

        // Round-robin among four single-beat requesters.
        do_reset();
        src_push(0, 8'h01, 1'b1);
        src_push(0, 8'h05, 1'b1);
        src_push(1, 8'h02, 1'b1);
        src_push(2, 8'h03, 1'b1);
        src_push(3, 8'h04, 1'b1);
`ifdef P2S_ARB_PRIO0_EN
        exp_push(0, 8'h01, 1'b1);
        exp_push(0, 8'h05, 1'b1);
        exp_push(1, 8'h02, 1'b1);
        exp_push(2, 8'h03, 1'b1);
        exp_push(3, 8'h04, 1'b1);
`else
        exp_push(0, 8'h01, 1'b1);
        exp_push(1, 8'h02, 1'b1);
        exp_push(2, 8'h03, 1'b1);
        exp_push(3, 8'h04, 1'b1);
        exp_push(0, 8'h05, 1'b1);
`endif
        drive_srcs();
        run_until_done(40, used);
        chk("t2_cycles_one_bubble", 32'(used), 32'd10);
        tick();

        // Backpressure mid-frame on source 1: m_rdy 1,0,0,1.
        do_reset();
        src_push(1, 8'h31, 1'b0); exp_push(1, 8'h31, 1'b0);
        src_push(1, 8'h32, 1'b0); exp_push(1, 8'h32, 1'b0);
        src_push(1, 8'h33, 1'b0); exp_push(1, 8'h33, 1'b0);
        src_push(1, 8'h34, 1'b1); exp_push(1, 8'h34, 1'b1);
        drive_srcs();
        tick();
        tick();
        m_rdy = 1'b0;
        tick();
        chk("t3_lock_stall1", 32'(busy), 32'd1);
        tick();
        chk("t3_lock_stall2", 32'(busy), 32'd1);
        chk("t3_sb_depth", 32'(sb.size()), 32'd3);
        m_rdy = 1'b1;
        run_until_done(20, used);
        tick();

        // Valid gap inside source 3's frame while source 0 waits.
        do_reset();
        src_push(3, 8'h41, 1'b0); exp_push(3, 8'h41, 1'b0);
        src_push(3, 8'h42, 1'b0); exp_push(3, 8'h42, 1'b0);
        src_push(3, 8'h43, 1'b0); exp_push(3, 8'h43, 1'b0);
        src_push(3, 8'h44, 1'b1); exp_push(3, 8'h44, 1'b1);
        drive_srcs();
        tick();
        chk("t4_grant3", 32'(grant_id), 32'd3);
        src_push(0, 8'h05, 1'b1); exp_push(0, 8'h05, 1'b1);
        drive_srcs();
        tick();
        gap[3] = 1'b1;
        drive_srcs();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_gap_grant", 32'(grant_id), 32'd3);
            chk("t4_gap_busy", 32'(busy), 32'd1);
        end
        gap[3] = 1'b0;
        drive_srcs();
        run_until_done(30, used);
        tick();

        // Reset during the second beat of source 1.
        do_reset();
        src_push(1, 8'h10, 1'b0); exp_push(1, 8'h10, 1'b0);
        src_push(1, 8'h11, 1'b0); exp_push(1, 8'h11, 1'b0);
        src_push(1, 8'h12, 1'b1); exp_push(1, 8'h12, 1'b1);
        drive_srcs();
        used = 0;
        while (sb.size() != 2 && used < 10) begin
            tick();
            used++;
        end
        chk("t5_mid_frame", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_m_vld", 32'(m_vld), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_s_rdy", 32'(s_rdy), 32'd0);
        chk("t5_rst_grant", 32'(grant_id), 32'd0);
        clear_all();
        for (int i = 0; i < NS; i++) begin
            src_push(i, 8'(8'h50 + i), 1'b1);
            exp_push(i, 8'(8'h50 + i), 1'b1);
        end
        drive_srcs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_first_after_rst", 32'(grant_id), 32'd0);
        chk("t5_busy_after_rst", 32'(busy), 32'd1);
        run_until_done(30, used);
        tick();

        // Sources 0 and 2 both requesting continuously.
        do_reset();
        src_push(0, 8'h60, 1'b1);
        src_push(0, 8'h62, 1'b1);
        src_push(2, 8'h61, 1'b1);
        src_push(2, 8'h63, 1'b1);
`ifdef P2S_ARB_PRIO0_EN
        exp_push(0, 8'h60, 1'b1);
        exp_push(0, 8'h62, 1'b1);
        exp_push(2, 8'h61, 1'b1);
        exp_push(2, 8'h63, 1'b1);
`else
        exp_push(0, 8'h60, 1'b1);
        exp_push(2, 8'h61, 1'b1);
        exp_push(0, 8'h62, 1'b1);
        exp_push(2, 8'h63, 1'b1);
`endif
        drive_srcs();
        run_until_done(30, used);
        chk("t6_cycles", 32'(used), 32'd8);
        tick();
        chk("t6_sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
